// File: rtl/btn_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer, 4-state qualify FSM, stability counter.
// Ports: clk, reset (async active-low), sw (raw input), db (debounced level), busy (qualifying).
module btn_debounce #(
  parameter int CNT_MAX = 1_000_000,
  parameter int CNT_W   = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db,
  output logic busy
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CNT_MAX - 1);

  logic             sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      busy_q  <= busy_d;
    end
  end

  // Counter is compared before incrementing and cleared on
  // every state change, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    busy_d  = busy_q;
    unique case (state_q)
      ZERO: begin
        if (sync2_q) begin
          state_d = WAIT1;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      WAIT1: begin
        if (!sync2_q) begin
          state_d = ZERO;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ONE;
          cnt_d   = '0;
          db_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ONE: begin
        if (!sync2_q) begin
          state_d = WAIT0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      WAIT0: begin
        if (sync2_q) begin
          state_d = ONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ZERO;
          cnt_d   = '0;
          db_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
        db_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign db   = db_q;
  assign busy = busy_q;

endmodule
